alu_ctrl_seq: RTL
=================

# alu_ctrl_seq

Registered, handshaked ALU control unit for the ID/EX boundary of the pipelined CPU. It decodes `ALUOp_i` and `funct_i` into an ALU operation code and presents that code to EX through a valid/ready handshake. It sequences multi-cycle multiply/divide operations with an internal latency counter, and supports stall and flush from the hazard unit.

## Interface
- `FUNCT_W`, default 6: width of `funct_i`; must be ≥6.
- `ALUOP_W`, default 3: width of `ALUOp_i`; must be ≥3.
- `CTRL_W`, default 4: width of `ALUCtrl_o`; must be ≥4.
- `MULDIV_LAT`, default 4: cycles from accept to `valid_o` for mult/div; must be ≥1.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `valid_i` in 1: decode request present.
- `ALUOp_i` in `ALUOP_W`: main-control ALU op class.
- `funct_i` in `FUNCT_W`: R-type function field.
- `ready_o` out 1: request accepted this cycle if `valid_i` is high.
- `valid_o` out 1: `ALUCtrl_o` valid for EX.
- `ALUCtrl_o` out `CTRL_W`: registered ALU operation code.
- `multi_o` out 1: current op is multiply/divide.
- `busy_o` out 1: multi-cycle op in progress.
- `stall_i` in 1: EX cannot take the output; hold it.
- `flush_i` in 1: synchronous kill of pending/held op.

## Operation
- **Decode.** Combinational. Zero-extend all codes to the port widths and compare against the full port value.
  - ALUOp 000→2, 001→6, 011→7, 100→10, 101→1, 110→9, 111→2, 010→funct table. Any other ALUOp→2.
  - Funct table: 100001→2, 100011→6, 100100→0, 100101→1, 101010→7, 000011→8, 000111→11, 011000 (mult)→12, 011010 (div)→13. Any other funct→2.
  - An op is multi-cycle only when ALUOp=010 and the result is 12 or 13.
- **Accept condition.** Accept = `valid_i & ready_o & ~flush_i`. `ready_o = ~busy_o & ~(valid_o & stall_i)`, combinational.
- **State machine.** States are IDLE, OUT, BUSY.
  - IDLE: `valid_o`=0. Accepting a single-cycle op → OUT. Accepting a multi-cycle op → BUSY if `MULDIV_LAT`>1, else → OUT.
  - OUT: `valid_o`=1.
    - `stall_i`=1 holds all outputs.
    - `stall_i`=0 without accept → IDLE.
    - `stall_i`=0 with accept loads the new op back-to-back, staying in OUT or going to BUSY.
  - BUSY: `valid_o`=0, `busy_o`=1. A counter loads `MULDIV_LAT-1` on accept and decrements each cycle. At count 1 → OUT. `stall_i` is ignored in BUSY.
- **Output loading.** On accept, register `ALUCtrl_o` and `multi_o` at the same edge. They remain stable through BUSY and OUT until the next accept, flush or reset.
- **Flush.** `flush_i` forces state IDLE, `valid_o`=0, `busy_o`=0, counter=0, `ALUCtrl_o`=2, `multi_o`=0. Flush overrides stall and any same-cycle accept; the input is dropped.
- **Reset.** All state above is cleared immediately on `rst_i`=0, including mid-BUSY. The reset values match the flush values.
- **Counter width.** `$clog2(MULDIV_LAT+1)`. The counter never wraps: the decrement is gated to BUSY.

## Timing
- Single-cycle op: accept at edge N, `valid_o`=1 after edge N.
- Multi-cycle op: `busy_o`=1 for `MULDIV_LAT-1` cycles, then `valid_o`=1. Total latency is `MULDIV_LAT` cycles.
- Throughput is one single-cycle op per cycle with no stall. A multi-cycle op blocks new accepts until it reaches OUT.
- `ready_o` has no dependence on `valid_i`, so there is no combinational loop with upstream.

## Test plan
- **Reset and basic decode.** Release reset. Apply ALUOp=010, funct=100011, valid_i=1 for one cycle. Required: next cycle `valid_o`=1, `ALUCtrl_o`=6, `multi_o`=0; the cycle after, `valid_o`=0.
- **Decode table sweep.** Stream all ALUOp values back-to-back, plus every funct table entry and one unknown funct (111111). Required: the output matches the table each cycle; unknown funct→2.
- **Multi-cycle op, `MULDIV_LAT`=4.** Accept mult (funct 011000).
  - Required: `busy_o`=1 and `ready_o`=0 for 3 cycles; then `valid_o`=1, `ALUCtrl_o`=12, `multi_o`=1.
  - A `valid_i` held high during BUSY is accepted only once OUT is reached and `stall_i`=0.
- **Stall.** `valid_o`=1 with `ALUCtrl_o`=7, `stall_i`=1 for 3 cycles. Required: the output holds 7 and `ready_o`=0. On release, the pending input is accepted that cycle.
- **Flush and reset mid-BUSY.** Flush on the second BUSY cycle of a div → next cycle IDLE, `ALUCtrl_o`=2, `busy_o`=0. Repeat with `rst_i`=0 asserted mid-BUSY → outputs clear immediately, with no clock edge required.
- **`MULDIV_LAT`=1 build.** div completes in 1 cycle with `multi_o`=1 and `busy_o` never asserted.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control unit at the ID/EX boundary: decodes the op class and funct field,
// hands the code to EX over valid/ready, and sequences multi-cycle mul/div.
module alu_ctrl_seq #(
   parameter int FUNCT_W    = 6,
   parameter int ALUOP_W    = 3,
   parameter int CTRL_W     = 4,
   parameter int MULDIV_LAT = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   input  logic [ALUOP_W-1:0] ALUOp_i,
   input  logic [FUNCT_W-1:0] funct_i,
   output logic               ready_o,
   output logic               valid_o,
   output logic [CTRL_W-1:0]  ALUCtrl_o,
   output logic               multi_o,
   output logic               busy_o,
   input  logic               stall_i,
   input  logic               flush_i
);

   localparam int CNT_W = $clog2(MULDIV_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_OUT,
      S_BUSY
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_valid;
   logic               r_busy;
   logic               r_multi;
   logic [CTRL_W-1:0]  r_ctrl;

   logic [CTRL_W-1:0]  w_fdec;
   logic [CTRL_W-1:0]  w_dec;
   logic               w_multi;
   logic               w_accept;

   always_comb begin
      w_fdec = CTRL_W'(2);
      unique case (1'b1)
         (funct_i == FUNCT_W'(6'b100001)): w_fdec = CTRL_W'(2);
         (funct_i == FUNCT_W'(6'b100011)): w_fdec = CTRL_W'(6);
         (funct_i == FUNCT_W'(6'b100100)): w_fdec = CTRL_W'(0);
         (funct_i == FUNCT_W'(6'b100101)): w_fdec = CTRL_W'(1);
         (funct_i == FUNCT_W'(6'b101010)): w_fdec = CTRL_W'(7);
         (funct_i == FUNCT_W'(6'b000011)): w_fdec = CTRL_W'(8);
         (funct_i == FUNCT_W'(6'b000111)): w_fdec = CTRL_W'(11);
         (funct_i == FUNCT_W'(6'b011000)): w_fdec = CTRL_W'(12);
         (funct_i == FUNCT_W'(6'b011010)): w_fdec = CTRL_W'(13);
         default:                          w_fdec = CTRL_W'(2);
      endcase
   end

   always_comb begin
      w_dec = CTRL_W'(2);
      unique case (1'b1)
         (ALUOp_i == ALUOP_W'(3'b000)): w_dec = CTRL_W'(2);
         (ALUOp_i == ALUOP_W'(3'b001)): w_dec = CTRL_W'(6);
         (ALUOp_i == ALUOP_W'(3'b010)): w_dec = w_fdec;
         (ALUOp_i == ALUOP_W'(3'b011)): w_dec = CTRL_W'(7);
         (ALUOp_i == ALUOP_W'(3'b100)): w_dec = CTRL_W'(10);
         (ALUOp_i == ALUOP_W'(3'b101)): w_dec = CTRL_W'(1);
         (ALUOp_i == ALUOP_W'(3'b110)): w_dec = CTRL_W'(9);
         (ALUOp_i == ALUOP_W'(3'b111)): w_dec = CTRL_W'(2);
         default:                       w_dec = CTRL_W'(2);
      endcase
   end

   assign w_multi  = (ALUOp_i == ALUOP_W'(3'b010)) &&
                     ((w_fdec == CTRL_W'(12)) || (w_fdec == CTRL_W'(13)));

   // ready never looks at valid_i, so upstream sees no combinational loop
   assign ready_o  = ~r_busy & ~(r_valid & stall_i);
   assign w_accept = valid_i & ready_o & ~flush_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_multi <= 1'b0;
         r_ctrl  <= CTRL_W'(2);
      end else if (flush_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_multi <= 1'b0;
         r_ctrl  <= CTRL_W'(2);
      end else if (w_accept) begin
         r_ctrl  <= w_dec;
         r_multi <= w_multi;
         if (w_multi && (MULDIV_LAT > 1)) begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_W'(MULDIV_LAT - 1);
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
         end else begin
            r_state <= S_OUT;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
         end
      end else begin
         unique case (r_state)
            S_OUT: begin
               if (!stall_i) begin
                  r_state <= S_IDLE;
                  r_valid <= 1'b0;
               end
            end
            S_BUSY: begin
               // count reaching 1 means this edge completes the latency
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= S_OUT;
                  r_cnt   <= '0;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign valid_o   = r_valid;
   assign busy_o    = r_busy;
   assign multi_o   = r_multi;
   assign ALUCtrl_o = r_ctrl;

endmodule
